fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WIDTH, default 8, width of the data word.
REQ-002 Parameter BURST_LEN, default 4, number of beats per burst; the last beat of each burst is flagged.
REQ-003 Parameter CNT_SIZE, default 2, width of the beat counter; the condition 2**CNT_SIZE >= BURST_LEN SHALL hold.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fifo_empty  input  1  empty flag of the upstream sync FIFO.
REQ-008 fifo_rd_data  input  WIDTH  registered FIFO read data, valid the cycle after fifo_rd_en is accepted.
REQ-009 fifo_rd_en  output  1  pop request to the FIFO.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  downstream accepts a word.
REQ-012 out_data  output  WIDTH  head word.
REQ-013 out_last  output  1  head word is the final beat of a burst.

Function
REQ-014 The block SHALL contain a 2-entry in-order output buffer with occupancy count in the range 0..2, plus a 1-bit pend flag that marks a FIFO read in flight.
REQ-015 fire is defined as out_valid && out_ready; a word leaves the buffer only on fire.
REQ-016 fifo_rd_en SHALL equal ~fifo_empty && ((count + pend - fire) < 2), which gives a combinational path from out_ready to fifo_rd_en.
REQ-017 pend SHALL be set on the cycle after fifo_rd_en=1, and cleared otherwise.
REQ-018 When pend=1, fifo_rd_data SHALL be written to the buffer tail on that posedge.
REQ-019 The next count SHALL equal count + pend - fire.
REQ-020 When pend and fire occur together, count SHALL be unchanged and the head SHALL advance.
REQ-021 The buffer SHALL never overflow: count + pend <= 2 at all times, and a violation is a design error.
REQ-022 out_valid SHALL equal (count > 0); FIFO data SHALL NOT bypass the buffer, so the minimum latency from fifo_rd_en to out_valid is 2 cycles.
REQ-023 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 Sustained throughput SHALL be 1 word per cycle when fifo_empty=0 and out_ready=1.
REQ-025 beat_cnt (CNT_SIZE bits) SHALL increment on each fire and wrap from BURST_LEN-1 to 0.
REQ-026 out_last SHALL equal out_valid && (beat_cnt == BURST_LEN-1).
REQ-027 When fifo_empty=1, no pop SHALL be issued.
REQ-028 A partially drained buffer SHALL continue to present words while fifo_empty=1; beat_cnt is not reset by empty.
REQ-029 If out_ready=0 and count=2, fifo_rd_en SHALL be 0.
REQ-030 If out_ready=0, count=1 and pend=1, fifo_rd_en SHALL be 0.
REQ-031 Word order on out_data SHALL equal FIFO pop order, with no duplication or loss, except under REQ-033.

Reset
REQ-032 While rst_n=0, the following SHALL be 0: count, pend, beat_cnt, buffer contents, fifo_rd_en, out_valid, out_last, out_data.
REQ-033 When reset asserts mid-operation, buffered and in-flight words SHALL be discarded.
REQ-034 After reset deasserts, the first fire SHALL be beat 0.

Verification
REQ-035 FIFO preloaded 0x01..0x08, out_ready=1 -> fifo_rd_en high from cycle 0; out_valid from cycle 2; out_data 0x01..0x08 on consecutive cycles; out_last on 0x04 and 0x08.
REQ-036 FIFO preloaded 0x10..0x13, out_ready=0 for 10 cycles then 1 -> exactly 2 pops, count=2, out_data=0x10 stable, then 0x10..0x13 back-to-back.
REQ-037 out_ready toggled 1,0,1,0 with a FIFO of 6 words -> all 6 words delivered in order, no duplicates; out_last on the 4th word only.
REQ-038 3 words, FIFO then empty for 5 cycles, then 1 more word -> out_last asserted on the 4th word; fifo_rd_en=0 throughout the empty period.
REQ-039 rst_n pulsed low with count=2 and pend=1 -> all outputs 0 asynchronously; the next word after reset has beat_cnt=0.
REQ-040 Random fifo_empty and out_ready for 10k cycles -> scoreboard order match, count + pend <= 2 always, and out_last exactly every BURST_LEN fires.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between an upstream sync FIFO, fifo_rd_stream and its downstream consumer.
// master: the fifo_rd_stream side; slave: the FIFO + consumer environment.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Converts a registered-read sync FIFO into a valid/ready stream through a 2-entry buffer,
// flagging the last beat of every BURST_LEN-word burst.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_SIZE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_rd_stream_if.master  bus
);

  localparam logic [CNT_SIZE-1:0] LAST_BEAT = CNT_SIZE'(BURST_LEN - 1);

  logic [1:0]          count;
  logic                pend;
  logic                head;
  logic [WIDTH-1:0]    mem [2];
  logic [CNT_SIZE-1:0] beat_cnt;

  logic                valid;
  logic                fire;
  logic [2:0]          occ_next;
  logic                wr_idx;

  always_comb begin
    valid    = (count != 2'd0);
    fire     = valid && bus.out_ready;
    occ_next = {1'b0, count} + {2'b0, pend} - {2'b0, fire};
    // Tail slot relative to the current head; valid also when pend and fire coincide.
    wr_idx   = head ^ count[0];
  end

  // Pop is held off during reset so nothing is lost from the FIFO while state is cleared.
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && (occ_next < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      pend     <= 1'b0;
      head     <= 1'b0;
      beat_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pend  <= bus.fifo_rd_en;
      count <= occ_next[1:0];
      if (pend) begin
        mem[wr_idx] <= bus.fifo_rd_data;
      end
      if (fire) begin
        head     <= ~head;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_valid = valid;
    bus.out_data  = valid ? mem[head] : '0;
    bus.out_last  = valid && (beat_cnt == LAST_BEAT);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count} + {2'b0, pend}) <= 3'd2);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_last)));

endmodule
